// File: rtl/key_scan_debounce_pkg.sv
// key_scan_debounce_pkg: event encodings and 12 MHz board timing defaults
package key_scan_debounce_pkg;
    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2
    } evt_type_e;
    localparam int DEF_DEB_CYCLES  = 240000;
    localparam int DEF_LONG_CYCLES = 12000000;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key's synchroniser, debouncer and long-hold detector
module key_debounce_ch
    import key_scan_debounce_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES    = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic state,
    output logic rise,
    output logic fall,
    output logic long_hit
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [1:0]    sync;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] hold;
    logic          lvl;
    logic          flip;
    assign lvl      = sync[1] ^ KEY_ACTIVE_LOW;
    assign flip     = (lvl != state) && (deb_cnt == DW'(DEB_CYCLES - 1));
    assign rise     = flip && !state;
    assign fall     = flip && state;
    // hold saturates one past the trigger value so the long event fires once per press
    assign long_hit = state && (hold == LW'(LONG_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= {2{KEY_ACTIVE_LOW}};
            state   <= 1'b0;
            deb_cnt <= '0;
            hold    <= '0;
        end else begin
            sync    <= {sync[0], key_in};
            state   <= state ^ flip;
            deb_cnt <= (lvl == state || flip) ? '0 : deb_cnt + 1'b1;
            hold    <= !state ? '0 : (hold == LW'(LONG_CYCLES)) ? hold : hold + 1'b1;
        end
    end
endmodule

// File: rtl/key_scan_debounce.sv
// key_scan_debounce: debounced key levels plus press/release/long events on a
// valid/ready port, lowest key first, press > long > release within a key.
module key_scan_debounce
    import key_scan_debounce_pkg::*;
#(
    parameter int KEY_NUM        = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES    = DEF_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_key,
    output logic [1:0]         evt_type,
    output logic               evt_overrun
);
    logic [KEY_NUM-1:0] rise, fall, long_hit;
    logic [KEY_NUM-1:0] pend_p, pend_l, pend_r;
    logic [KEY_NUM-1:0] keep_p, keep_l, keep_r, onehot;
    logic               found, load, take, lost;
    logic [2:0]         sel_key;
    evt_type_e          sel_type;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
        key_debounce_ch #(
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .key_in  (key_in[k]),
            .state   (key_state[k]),
            .rise    (rise[k]),
            .fall    (fall[k]),
            .long_hit(long_hit[k])
        );
    end

    // descending scan so the lowest pending key is the one left selected
    always_comb begin
        found    = 1'b0;
        sel_key  = 3'd0;
        sel_type = EVT_PRESS;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (pend_p[i] || pend_l[i] || pend_r[i]) begin
                found    = 1'b1;
                sel_key  = 3'(i);
                sel_type = pend_p[i] ? EVT_PRESS : pend_l[i] ? EVT_LONG : EVT_RELEASE;
            end
        end
    end

    assign load   = !evt_valid || evt_ready;
    assign take   = load && found;
    assign onehot = KEY_NUM'(1) << sel_key;
    assign keep_p = pend_p & ~((take && sel_type == EVT_PRESS)   ? onehot : '0);
    assign keep_l = pend_l & ~((take && sel_type == EVT_LONG)    ? onehot : '0);
    assign keep_r = pend_r & ~((take && sel_type == EVT_RELEASE) ? onehot : '0);
    assign lost   = |((keep_p & rise) | (keep_l & long_hit) | (keep_r & fall));

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p      <= '0;
            pend_l      <= '0;
            pend_r      <= '0;
            evt_valid   <= 1'b0;
            evt_key     <= 3'd0;
            evt_type    <= 2'd0;
            evt_overrun <= 1'b0;
        end else begin
            pend_p      <= keep_p | rise;
            pend_l      <= keep_l | long_hit;
            pend_r      <= keep_r | fall;
            evt_overrun <= evt_overrun | lost;
            if (load) evt_valid <= found;
            if (take) begin
                evt_key  <= sel_key;
                evt_type <= sel_type;
            end
        end
    end
endmodule

// File: tb/tb_key_scan_debounce.sv
// tb_key_scan_debounce: directed and random key stimulus against a
// window/timestamp based reference model of the debounced event stream.
module tb_key_scan_debounce;
    localparam int DEB  = 8;
    localparam int LONG = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic [3:0] key_state;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [2:0] evt_key;
    logic [1:0] evt_type;
    logic       evt_overrun;

    key_scan_debounce #(
        .KEY_NUM(4), .KEY_ACTIVE_LOW(1'b1), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_state(key_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_type(evt_type), .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int dut_evts = 0;
    logic [1:0] k2q[$];

    logic [3:0] lvq[$];
    logic [3:0] m_state;
    int         m_rise[4];
    bit [2:0]   m_pend[4];
    logic       m_valid, m_ovr;
    logic [2:0] m_key;
    logic [1:0] m_type;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 4'h0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_key   = 3'd0;
        m_type  = 2'd0;
        lvq = {};
        for (int j = 0; j < DEB + 2; j++) lvq.push_back(4'h0);
        for (int k = 0; k < 4; k++) begin
            m_pend[k] = 3'b000;
            m_rise[k] = 0;
        end
    endtask

    // pressed level seen by the debouncer lags the pin by two edges; a key
    // flips once its last DEB seen levels all disagree with its current state
    task automatic model_edge(input logic [3:0] norm, input bit rdy);
        bit fl[4];
        bit lg[4];
        bit found;
        bit load;
        int fk;
        int ft;
        int ord[3];
        found = 0;
        fk = 0;
        ft = 0;
        ord = '{0, 2, 1};
        lvq.push_back(norm);
        while (lvq.size() > DEB + 2) void'(lvq.pop_front());
        for (int k = 0; k < 4; k++) begin
            fl[k] = 1;
            for (int j = 0; j < DEB; j++) if (lvq[j][k] == m_state[k]) fl[k] = 0;
            lg[k] = m_state[k] && (cyc - m_rise[k] == LONG);
        end
        load = !m_valid || rdy;
        for (int k = 0; k < 4; k++)
            for (int o = 0; o < 3; o++)
                if (!found && m_pend[k][ord[o]]) begin
                    found = 1;
                    fk = k;
                    ft = ord[o];
                end
        if (load && found) m_pend[fk][ft] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (fl[k]) begin
                int t;
                t = m_state[k] ? 1 : 0;
                if (m_pend[k][t]) m_ovr = 1'b1;
                m_pend[k][t] = 1'b1;
            end
            if (lg[k]) begin
                if (m_pend[k][2]) m_ovr = 1'b1;
                m_pend[k][2] = 1'b1;
            end
        end
        if (load) begin
            m_valid = found;
            if (found) begin
                m_key  = 3'(fk);
                m_type = 2'(ft);
            end
        end
        for (int k = 0; k < 4; k++)
            if (fl[k]) begin
                m_state[k] = ~m_state[k];
                if (m_state[k]) m_rise[k] = cyc;
            end
    endtask

    task automatic check_all();
        chk("key_state", 8'(key_state), 8'(m_state));
        chk("evt_valid", 8'(evt_valid), 8'(m_valid));
        chk("evt_overrun", 8'(evt_overrun), 8'(m_ovr));
        if (m_valid) begin
            chk("evt_key", 8'(evt_key), 8'(m_key));
            chk("evt_type", 8'(evt_type), 8'(m_type));
        end
    endtask

    task automatic tick();
        logic [3:0] norm;
        bit r;
        bit rdy;
        norm = ~key_in;
        r = rst;
        rdy = evt_ready;
        if (evt_valid && evt_ready) begin
            dut_evts++;
            if (evt_key == 3'd2) k2q.push_back(evt_type);
        end
        @(posedge clk);
        cyc++;
        if (r) model_reset();
        else model_edge(norm, rdy);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int base;
        int hold_len;
        // 1: reset with all keys released
        ticks(3);
        rst = 1'b0;
        chk("rst_key_state", 8'(key_state), 8'h00);
        chk("rst_evt_valid", 8'(evt_valid), 8'h00);
        chk("rst_overrun", 8'(evt_overrun), 8'h00);
        ticks(4);
        // 2: key0 press/release latency and events
        key_in = 4'hE;
        ticks(9);
        chk("t2_before", 8'(key_state[0]), 8'h00);
        tick();
        chk("t2_pressed", 8'(key_state[0]), 8'h01);
        tick();
        chk("t2_press_valid", 8'(evt_valid), 8'h01);
        chk("t2_press_key", 8'(evt_key), 8'h00);
        chk("t2_press_type", 8'(evt_type), 8'h00);
        ticks(9);
        key_in = 4'hF;
        ticks(10);
        chk("t2_released", 8'(key_state[0]), 8'h00);
        tick();
        chk("t2_rel_valid", 8'(evt_valid), 8'h01);
        chk("t2_rel_type", 8'(evt_type), 8'h01);
        ticks(15);
        // 3: short glitch on key1 is ignored
        base = dut_evts;
        key_in = 4'hD;
        ticks(5);
        key_in = 4'hF;
        ticks(15);
        chk("t3_no_event", 8'(dut_evts - base), 8'h00);
        chk("t3_state", 8'(key_state), 8'h00);
        // 4: key2 held long: press, one long, release
        k2q = {};
        key_in = 4'hB;
        ticks(50);
        key_in = 4'hF;
        ticks(15);
        chk("t4_count", 8'(k2q.size()), 8'd3);
        if (k2q.size() == 3) begin
            chk("t4_first", 8'(k2q[0]), 8'd0);
            chk("t4_second", 8'(k2q[1]), 8'd2);
            chk("t4_third", 8'(k2q[2]), 8'd1);
        end
        // 5: simultaneous presses with consumer stalled
        evt_ready = 1'b0;
        key_in = 4'h6;
        ticks(20);
        chk("t5_hold_valid", 8'(evt_valid), 8'h01);
        chk("t5_hold_key", 8'(evt_key), 8'h00);
        chk("t5_hold_type", 8'(evt_type), 8'h00);
        evt_ready = 1'b1;
        tick();
        chk("t5_next_key", 8'(evt_key), 8'h03);
        chk("t5_next_type", 8'(evt_type), 8'h00);
        key_in = 4'hF;
        ticks(50);
        // 6: lost events set overrun, reset clears everything mid-hold
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_in = (i % 2 == 0) ? 4'hE : 4'hF;
            ticks(12);
        end
        chk("t6_overrun", 8'(evt_overrun), 8'h01);
        key_in = 4'hE;
        ticks(15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_state", 8'(key_state), 8'h00);
        chk("t6_rst_valid", 8'(evt_valid), 8'h00);
        chk("t6_rst_overrun", 8'(evt_overrun), 8'h00);
        chk("t6_rst_key", 8'(evt_key), 8'h00);
        chk("t6_rst_type", 8'(evt_type), 8'h00);
        evt_ready = 1'b1;
        key_in = 4'hF;
        ticks(20);
        // random pins and consumer backpressure
        for (int n = 0; n < 300; n++) begin
            key_in = 4'($urandom);
            hold_len = $urandom_range(1, 25);
            for (int c = 0; c < hold_len; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
